// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: machine-level external interrupt controller.
// Merges NUM_SRC asynchronous peripheral interrupt lines into a single
// machine_external_interrupt request. Each source has a two-flop
// synchroniser, a level/edge gateway, an enable bit and a priority. The
// highest-priority eligible source is presented through a claim/complete
// register on the data-memory bus.
//
// Ports:
//   clk                        system clock
//   rst                        asynchronous active-low reset
//   irq_src[NUM_SRC]           raw interrupt lines (asynchronous)
//   cfg_re / cfg_we            one-cycle register read / write strobes
//   cfg_adr[6]                 word address
//   cfg_wdata[32]              write data
//   cfg_rdata[32]              registered read data, held until next read
//   machine_external_interrupt registered interrupt request to the core
module ext_int_ctrl #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               cfg_re,
    input  logic               cfg_we,
    input  logic [5:0]         cfg_adr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               machine_external_interrupt
);

    localparam int unsigned ID_W = 5;

    localparam logic [5:0] ADR_ENABLE    = 6'd0;
    localparam logic [5:0] ADR_MODE      = 6'd1;
    localparam logic [5:0] ADR_PENDING   = 6'd2;
    localparam logic [5:0] ADR_THRESHOLD = 6'd3;
    localparam logic [5:0] ADR_CLAIM     = 6'd4;
    localparam int unsigned ADR_PRIO_BASE = 8;

    logic [NUM_SRC-1:0] enable_r;
    logic [NUM_SRC-1:0] mode_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] in_service_r;
    logic [NUM_SRC-1:0] sync1, sync2, sync3;
    logic [PRIO_W-1:0]  threshold_r;
    logic [PRIO_W-1:0]  prio_r [NUM_SRC];

    logic [ID_W-1:0]    best_id, arb_id;
    logic [PRIO_W-1:0]  best_prio, arb_prio;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] claim_hit;
    logic [NUM_SRC-1:0] complete_hit;
    logic               claim_rd;
    logic               claim_valid;
    logic [31:0]        rd_mux;

    // Eligibility and priority arbitration; strict '>' keeps the lowest ID on ties.
    always_comb begin
        arb_id   = '0;
        arb_prio = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending_r[i] & enable_r[i] & ~in_service_r[i] & (prio_r[i] != '0);
            if (eligible[i] && (prio_r[i] > arb_prio)) begin
                arb_id   = ID_W'(i + 1);
                arb_prio = prio_r[i];
            end
        end
    end

    // A claim is only honoured if the registered best_id is still eligible
    // now; this masks a stale best_id on back-to-back claims.
    always_comb begin
        claim_rd = cfg_re & ~cfg_we & (cfg_adr == ADR_CLAIM);
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            claim_hit[i]    = claim_rd & (best_id == ID_W'(i + 1)) & eligible[i];
            complete_hit[i] = cfg_we & (cfg_adr == ADR_CLAIM) & (cfg_wdata[5:0] == 6'(i + 1));
        end
        claim_valid = |claim_hit;
    end

    always_comb begin
        rd_mux = '0;
        case (cfg_adr)
            ADR_ENABLE:    rd_mux = 32'(enable_r);
            ADR_MODE:      rd_mux = 32'(mode_r);
            ADR_PENDING:   rd_mux = 32'(pending_r);
            ADR_THRESHOLD: rd_mux = 32'(threshold_r);
            ADR_CLAIM:     rd_mux = claim_valid ? 32'(best_id) : '0;
            default: begin
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    if (cfg_adr == 6'(ADR_PRIO_BASE + i)) rd_mux = 32'(prio_r[i]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_r     <= '0;
            mode_r       <= '0;
            pending_r    <= '0;
            in_service_r <= '0;
            sync1        <= '0;
            sync2        <= '0;
            sync3        <= '0;
            threshold_r  <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) prio_r[i] <= '0;
            best_id      <= '0;
            best_prio    <= '0;
            cfg_rdata    <= '0;
            machine_external_interrupt <= 1'b0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
            sync3 <= sync2;

            if (cfg_we) begin
                case (cfg_adr)
                    ADR_ENABLE:    enable_r    <= cfg_wdata[NUM_SRC-1:0];
                    ADR_MODE:      mode_r      <= cfg_wdata[NUM_SRC-1:0];
                    ADR_THRESHOLD: threshold_r <= cfg_wdata[PRIO_W-1:0];
                    default: begin
                        for (int unsigned i = 0; i < NUM_SRC; i++) begin
                            if (cfg_adr == 6'(ADR_PRIO_BASE + i)) prio_r[i] <= cfg_wdata[PRIO_W-1:0];
                        end
                    end
                endcase
            end

            // Gateway: an edge arriving with its own claim survives; in level
            // mode the claim wins over the still-high line.
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (mode_r[i] && sync2[i] && !sync3[i])
                    pending_r[i] <= 1'b1;
                else if (claim_hit[i])
                    pending_r[i] <= 1'b0;
                else if (!mode_r[i] && sync2[i] && !in_service_r[i])
                    pending_r[i] <= 1'b1;

                if (claim_hit[i])
                    in_service_r[i] <= 1'b1;
                else if (complete_hit[i])
                    in_service_r[i] <= 1'b0;
            end

            best_id   <= arb_id;
            best_prio <= arb_prio;
            machine_external_interrupt <= (arb_id != '0) && (arb_prio > threshold_r);

            if (cfg_re) cfg_rdata <= cfg_we ? '0 : rd_mux;
        end
    end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Self-checking bench for ext_int_ctrl (NUM_SRC = 8, PRIO_W = 3).
module tb_ext_int_ctrl;

    localparam int NSRC = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] irq_src;
    logic            cfg_re, cfg_we;
    logic [5:0]      cfg_adr;
    logic [31:0]     cfg_wdata;
    logic [31:0]     cfg_rdata;
    logic            mei;

    int pass_cnt = 0;
    int total_cnt = 0;

    ext_int_ctrl #(.NUM_SRC(NSRC), .PRIO_W(3)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .irq_src                    (irq_src),
        .cfg_re                     (cfg_re),
        .cfg_we                     (cfg_we),
        .cfg_adr                    (cfg_adr),
        .cfg_wdata                  (cfg_wdata),
        .cfg_rdata                  (cfg_rdata),
        .machine_external_interrupt (mei)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  adr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [5:0] adr, input logic [31:0] data);
        cfg_adr = adr; cfg_wdata = data; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [5:0] adr, output logic [31:0] data);
        cfg_adr = adr; cfg_re = 1'b1;
        tick();
        data = cfg_rdata;
        cfg_re = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; irq_src = '0; cfg_re = 1'b0; cfg_we = 1'b0;
        cfg_adr = '0; cfg_wdata = '0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Reference: claim order is highest priority first, lowest ID on ties,
    // among raised sources that are enabled and have non-zero priority.
    task automatic random_round(input int r);
        logic [NSRC-1:0] en, md, irq, rem;
        int unsigned pr[NSRC];
        int unsigned thr, best, bp;
        logic [31:0] d;
        do_reset();
        en  = NSRC'($urandom);
        md  = NSRC'($urandom);
        irq = NSRC'($urandom);
        thr = $urandom_range(0, 7);
        for (int i = 0; i < NSRC; i++) begin
            pr[i] = $urandom_range(0, 7);
            wr(6'(8 + i), pr[i]);
        end
        wr(6'd1, 32'(md));
        wr(6'd3, thr);
        wr(6'd0, 32'(en));
        irq_src = irq;
        tick(6);
        rd(6'd2, d);
        check($sformatf("rnd%0d pending", r), d, 32'(irq));
        rem = '0;
        for (int i = 0; i < NSRC; i++) rem[i] = irq[i] & en[i] & (pr[i] != 0);
        for (int k = 0; k <= NSRC; k++) begin
            best = 0; bp = 0;
            for (int i = 0; i < NSRC; i++)
                if (rem[i] && pr[i] > bp) begin best = i + 1; bp = pr[i]; end
            check($sformatf("rnd%0d mei k%0d", r, k), 32'(mei), 32'((best != 0) && (bp > thr)));
            rd(6'd4, d);
            check($sformatf("rnd%0d claim k%0d", r, k), d, best);
            if (best == 0) break;
            rem[best-1] = 1'b0;
            tick(4);
        end
    endtask

    initial begin
        logic [31:0] d, d1, d2, d3;

        // Reset with all lines high: outputs 0, and nothing fires with ENABLE = 0.
        rst = 1'b0; irq_src = '1; cfg_re = 1'b0; cfg_we = 1'b0;
        cfg_adr = '0; cfg_wdata = '0;
        tick(2);
        check("reset mei", 32'(mei), 0);
        check("reset rdata", cfg_rdata, 0);
        rst = 1'b1;
        tick(8);
        check("disabled mei", 32'(mei), 0);
        rd(6'd2, d);
        check("disabled pending", d, 32'hFF);

        // Register access table: truncation, zero-extension, unmapped addresses.
        do_reset();
        vecs[0]  = '{6'd0,  32'hFFFF_FFFF, 32'h0000_00FF};
        vecs[1]  = '{6'd1,  32'h0000_01A5, 32'h0000_00A5};
        vecs[2]  = '{6'd2,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{6'd3,  32'hFFFF_FFFE, 32'h0000_0006};
        vecs[4]  = '{6'd8,  32'h0000_001D, 32'h0000_0005};
        vecs[5]  = '{6'd15, 32'h0000_000F, 32'h0000_0007};
        vecs[6]  = '{6'd16, 32'h0000_0007, 32'h0000_0000};
        vecs[7]  = '{6'd5,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8]  = '{6'd63, 32'h0000_0001, 32'h0000_0000};
        vecs[9]  = '{6'd0,  32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{6'd1,  32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{6'd3,  32'h0000_0000, 32'h0000_0000};
        vecs[12] = '{6'd8,  32'h0000_0000, 32'h0000_0000};
        vecs[13] = '{6'd15, 32'h0000_0000, 32'h0000_0000};
        for (int v = 0; v < 14; v++) begin
            wr(vecs[v].adr, vecs[v].wdata);
            rd(vecs[v].adr, d);
            check($sformatf("reg vec%0d adr%0d", v, vecs[v].adr), d, vecs[v].exp);
        end

        // Level source 3: latency, claim, complete while high, complete after low.
        do_reset();
        wr(6'd10, 5); wr(6'd3, 2); wr(6'd0, 32'h04);
        irq_src[2] = 1'b1;
        tick(3);
        check("lvl3 mei early", 32'(mei), 0);
        tick();
        check("lvl3 mei at 4", 32'(mei), 1);
        rd(6'd4, d);
        check("lvl3 claim", d, 3);
        tick();
        check("lvl3 mei drop", 32'(mei), 0);
        wr(6'd4, 3);
        tick(3);
        check("lvl3 mei reassert", 32'(mei), 1);
        rd(6'd4, d);
        check("lvl3 claim2", d, 3);
        irq_src[2] = 1'b0;
        tick(4);
        wr(6'd4, 3);
        tick(4);
        check("lvl3 mei quiet", 32'(mei), 0);
        rd(6'd4, d);
        check("lvl3 claim none", d, 0);

        // Sources 2 and 5, equal priority, back-to-back claims.
        do_reset();
        wr(6'd9, 4); wr(6'd12, 4); wr(6'd0, 32'h12);
        irq_src = 8'h12;
        tick(6);
        cfg_adr = 6'd4; cfg_re = 1'b1;
        tick(); d1 = cfg_rdata;
        tick(); d2 = cfg_rdata;
        tick(); d3 = cfg_rdata;
        cfg_re = 1'b0;
        check("tie claim first", d1, 2);
        check("tie claim stale", d2, 0);
        check("tie claim second", d3, 5);

        // Edge source 1: pulses while in service merge into one pending.
        do_reset();
        wr(6'd1, 1); wr(6'd8, 3); wr(6'd0, 1);
        irq_src[0] = 1'b1; tick(2); irq_src[0] = 1'b0; tick(4);
        check("edge mei", 32'(mei), 1);
        rd(6'd4, d);
        check("edge claim", d, 1);
        repeat (2) begin
            irq_src[0] = 1'b1; tick(2); irq_src[0] = 1'b0; tick(3);
        end
        rd(6'd2, d);
        check("edge pending merged", d, 1);
        wr(6'd4, 1);
        tick(3);
        rd(6'd4, d);
        check("edge claim again", d, 1);
        tick(4);
        rd(6'd4, d);
        check("edge claim empty", d, 0);
        check("edge mei off", 32'(mei), 0);

        // Threshold boundary, simultaneous read+write, bad complete IDs.
        do_reset();
        wr(6'd8, 5); wr(6'd3, 5); wr(6'd0, 1);
        irq_src[0] = 1'b1;
        tick(6);
        check("thr5 mei", 32'(mei), 0);
        wr(6'd3, 4);
        tick(3);
        check("thr4 mei", 32'(mei), 1);
        cfg_adr = 6'd4; cfg_wdata = 0; cfg_re = 1'b1; cfg_we = 1'b1;
        tick();
        cfg_re = 1'b0; cfg_we = 1'b0;
        check("re+we rdata", cfg_rdata, 0);
        tick(3);
        check("re+we no claim", 32'(mei), 1);
        rd(6'd4, d);
        check("thr claim", d, 1);
        tick(3);
        check("claimed mei", 32'(mei), 0);
        wr(6'd4, 0); wr(6'd4, 9);
        tick(4);
        check("bad complete mei", 32'(mei), 0);
        rd(6'd2, d);
        check("bad complete pending", d, 0);
        wr(6'd4, 1);
        tick(4);
        check("good complete mei", 32'(mei), 1);
        rd(6'd3, d);
        check("thr readback", d, 4);

        // Asynchronous reset mid-service.
        #2 rst = 1'b0;
        #1;
        check("async rst mei", 32'(mei), 0);
        check("async rst rdata", cfg_rdata, 0);
        irq_src = '0;
        tick();
        rst = 1'b1;
        tick();
        rd(6'd0, d); check("post rst enable", d, 0);
        rd(6'd3, d); check("post rst threshold", d, 0);
        rd(6'd8, d); check("post rst prio0", d, 0);
        rd(6'd2, d); check("post rst pending", d, 0);

        // Randomised rounds against the claim-order model.
        for (int r = 0; r < 30; r++) random_round(r);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ext_int_ctrl.md
# ext_int_ctrl

Parametrised machine-level external interrupt controller that merges `NUM_SRC` peripheral interrupt lines into the single `machine_external_interrupt` input of the RV32I trap datapath. Each source has:
- an input synchroniser;
- a level/edge gateway;
- a programmable priority and an enable bit.

The highest-priority eligible source is presented through a memory-mapped claim/complete register, so a trap handler can identify, service and retire individual sources. It sits between the peripherals and the core, on the data-memory bus.

## Interface
Parameters:
- `NUM_SRC`, 8, number of sources, 1..31; source ID = bit index + 1, ID 0 = none
- `PRIO_W`, 3, priority/threshold width, 1..8

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `irq_src`  in  NUM_SRC  raw peripheral interrupt lines, asynchronous
- `cfg_re`  in  1  register read strobe, one cycle
- `cfg_we`  in  1  register write strobe, one cycle
- `cfg_adr`  in  6  word address
- `cfg_wdata`  in  32  write data
- `cfg_rdata`  out  32  read data, registered
- `machine_external_interrupt`  out  1  interrupt request to the core, registered

## Operation
Register map (word address):
- 0 ENABLE: RW, bit i enables source i+1
- 1 MODE: RW, bit i: 1 = edge, 0 = level
- 2 PENDING: RO
- 3 THRESHOLD: RW, PRIO_W bits
- 4 CLAIM: read = claim, write = complete
- 8+i PRIORITY[i]: RW, PRIO_W bits, 0 = never interrupts

Register access rules:
- Writes are truncated to the implemented width.
- Reads are zero-extended.
- Unmapped addresses, and bits at or above NUM_SRC, read 0 and ignore writes.

Synchroniser and gateway:
- Each source passes through two flops (s2), plus one delay flop s3 for edge detection.
- Level mode: pending[i] is set when s2 = 1 and in_service[i] = 0.
- Edge mode: pending[i] is set when s2 = 1 and s3 = 0, regardless of in_service. Pending is one deep, so further edges while pending are merged.

Arbitration:
- eligible[i] = pending[i] & enable[i] & !in_service[i] & (priority[i] != 0).
- Combinational maximum priority across eligible sources; ties go to the lowest ID.
- The result is registered as best_id and best_prio every cycle.
- machine_external_interrupt = (best_prio > THRESHOLD) with best_id != 0, registered.

Claim (cfg_re at address 4):
- cfg_rdata = best_id, but only if that source is still eligible this cycle; otherwise cfg_rdata = 0 and there is no side effect. This masks stale best_id on back-to-back claims.
- On a valid claim: clear pending[best_id-1] and set in_service[best_id-1].

Complete (cfg_we at address 4):
- Clears in_service[wdata-1] when wdata[5:0] is in 1..NUM_SRC; any other value is ignored.
- For a level source still high, pending re-sets in the next cycle.

Other behaviour:
- Clearing ENABLE does not clear pending or in_service.
- cfg_re and cfg_we asserted together: the write is performed, the read returns 0 with no claim side effect.
- Edge mode, new edge in the same cycle as the claim of that source: pending stays 1 (the edge is not lost).
- Level mode, same situation: the claim wins.

## Timing
- Reset (rst = 0, asynchronous) clears everything to 0: all registers, pending, in_service, synchronisers, best_id, best_prio, cfg_rdata and machine_external_interrupt.
- irq_src rising before edge k:
  - s2 = 1 after edge k+1;
  - pending = 1 after edge k+2;
  - best registered and machine_external_interrupt = 1 after edge k+3.
- Read latency: cfg_rdata is valid after the edge that samples cfg_re, and holds until the next read.
- Claim sampled at edge N: pending and in_service update at N. machine_external_interrupt drops after edge N+1 when no other source is above threshold.
- Configuration writes take effect on the arbitration result 1 cycle later, and on the output 1 cycle after that.

## Test plan
- Reset with irq_src = all 1s:
  - every output is 0;
  - after rst deassertion with ENABLE = 0, machine_external_interrupt stays 0.
- Level source 3 (PRIORITY = 5, THRESHOLD = 2, enabled):
  - assert irq_src[2] → interrupt asserts 4 cycles later;
  - claim returns 3 → interrupt drops;
  - complete(3) while still high → interrupt reasserts;
  - complete(3) after deasserting → interrupt stays 0.
- Sources 2 and 5 with equal priority 4 both pending:
  - claim returns 2, then a back-to-back claim returns 0 (stale masked);
  - the next claim returns 5.
- Edge source 1:
  - two pulses while in_service → one pending;
  - after complete, claim returns 1 once, then returns 0.
- THRESHOLD = 5 with source priority 5 → no interrupt. THRESHOLD = 4 → interrupt.
- Complete with ID 0 or NUM_SRC+1 → no state change.
- rst pulse mid-service → all state cleared.
